// File: rtl/branch_fwd_scoreboard_pkg.sv
// Shared types for the ID-stage branch forwarding scoreboard: entry struct, stage indices, readiness rule.
// Latency: n/a (types and functions only). Backpressure: n/a.
package branch_fwd_scoreboard_pkg;

  // Entries store rd at a fixed width; any REG_AW up to this value zero-extends into it.
  localparam int REG_AW_MAX = 8;

  localparam int FWD_SEL_RF = 0;

  localparam int STAGE_EX  = 1;
  localparam int STAGE_MEM = 2;
  localparam int STAGE_WB  = 3;

  typedef struct packed {
    logic                  v;
    logic [REG_AW_MAX-1:0] rd;
    logic                  ld;
  } sb_entry_t;

  function automatic logic stage_ready(input int k, input logic ld,
                                       input int alu_rdy, input int load_rdy);
    return k >= (ld ? load_rdy : alu_rdy);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Youngest-producer search for one branch source operand: emits a forwarding select or a stall.
// Latency: combinational. Backpressure: none; stall is an output to the pipeline control.
module fwd_src_match
  import branch_fwd_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int ALU_RDY  = 2,
  parameter int LOAD_RDY = 3,
  parameter int SEL_W    = 2
) (
  input  logic              check_en,
  input  logic [REG_AW-1:0] src,
  input  sb_entry_t         sb [1:DEPTH],
  output logic [SEL_W-1:0]  sel,
  output logic              stall
);

  logic found;

  // Lowest k is the youngest producer; once found, older entries are ignored.
  always_comb begin
    sel   = SEL_W'(FWD_SEL_RF);
    stall = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (!found && check_en && (src != '0) && sb[k].v &&
          (sb[k].rd == REG_AW_MAX'(src))) begin
        found = 1'b1;
        if (stage_ready(k, sb[k].ld, ALU_RDY, LOAD_RDY))
          sel = SEL_W'(k);
        else
          stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_fwd_scoreboard.sv
// Branch operand forwarding/stall scoreboard beside ID; optional counters under BRANCH_FWD_STATS_EN.
// Latency: outputs combinational from held entries and ID inputs; entries shift one stage per unfrozen cycle.
// Backpressure: pipe_freeze holds every entry; stall_id requests a bubble until the producer is ready.
module branch_fwd_scoreboard
  import branch_fwd_scoreboard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int DEPTH    = STAGE_WB,
  parameter int ALU_RDY  = STAGE_MEM,
  parameter int LOAD_RDY = STAGE_WB,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       id_valid,
  input  logic                       id_is_branch,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_reg_write,
  input  logic                       id_mem_read,
  input  logic                       id_flush,
  input  logic                       pipe_freeze,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
  output logic                       stall_id,
  output logic [NUM_SRC-1:0]         stall_src
`ifdef BRANCH_FWD_STATS_EN
  ,
  output logic [31:0]                stat_stall_cycles,
  output logic [31:0]                stat_fwd_events
`endif
);

  sb_entry_t sb [1:DEPTH];
  logic      check_en;

  assign check_en = id_valid & id_is_branch & ~id_flush;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_AW   (REG_AW),
      .DEPTH    (DEPTH),
      .ALU_RDY  (ALU_RDY),
      .LOAD_RDY (LOAD_RDY),
      .SEL_W    (SEL_W)
    ) u_match (
      .check_en (check_en & id_src_used[i]),
      .src      (id_src[i*REG_AW +: REG_AW]),
      .sb       (sb),
      .sel      (fwd_sel[i*SEL_W +: SEL_W]),
      .stall    (stall_src[i])
    );
  end

  assign stall_id = |stall_src;

  // A stalled or flushed ID instruction enters EX as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
    end else if (!pipe_freeze) begin
      for (int k = DEPTH; k >= 2; k--) sb[k] <= sb[k-1];
      sb[1] <= '{v:  id_valid & id_reg_write & (id_rd != '0) & ~stall_id & ~id_flush,
                 rd: REG_AW_MAX'(id_rd),
                 ld: id_mem_read};
    end
  end

`ifdef BRANCH_FWD_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_cycles <= '0;
      stat_fwd_events   <= '0;
    end else if (!pipe_freeze) begin
      if (stall_id && (stat_stall_cycles != '1))
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if ((|fwd_sel) && !stall_id && (stat_fwd_events != '1))
        stat_fwd_events <= stat_fwd_events + 32'd1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_fwd_scoreboard.sv
// Directed bench for branch_fwd_scoreboard: producer-age queue model checked every cycle plus literal pins.
// Optional counter ports are connected and checked when BRANCH_FWD_STATS_EN is defined.
module tb_branch_fwd_scoreboard;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int D  = 3;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            id_valid, id_is_branch, id_reg_write, id_mem_read, id_flush, pipe_freeze;
  logic [NS*AW-1:0] id_src;
  logic [NS-1:0]   id_src_used;
  logic [AW-1:0]   id_rd;
  logic [NS*SW-1:0] fwd_sel;
  logic            stall_id;
  logic [NS-1:0]   stall_src;
`ifdef BRANCH_FWD_STATS_EN
  logic [31:0]     stat_stall_cycles, stat_fwd_events;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_fwd_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_is_branch (id_is_branch),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_flush     (id_flush),
    .pipe_freeze  (pipe_freeze),
    .fwd_sel      (fwd_sel),
    .stall_id     (stall_id),
    .stall_src    (stall_src)
`ifdef BRANCH_FWD_STATS_EN
    ,
    .stat_stall_cycles (stat_stall_cycles),
    .stat_fwd_events   (stat_fwd_events)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  // Model: list of in-flight writers with their age in stages after ID.
  typedef struct { int rd; bit ld; int age; } prod_t;
  prod_t q[$];
  int    m_stall_cnt = 0;
  int    m_fwd_cnt   = 0;
  bit    started     = 0;

  function automatic void model_out(output logic [NS*SW-1:0] sel, output logic [NS-1:0] ss);
    sel = '0;
    ss  = '0;
    if (id_valid && id_is_branch && !id_flush) begin
      for (int i = 0; i < NS; i++) begin
        int s;
        int best;
        bit bld;
        s    = int'(id_src[i*AW +: AW]);
        best = D + 1;
        bld  = 0;
        if (id_src_used[i] && s != 0) begin
          foreach (q[j]) if (q[j].rd == s && q[j].age < best) begin
            best = q[j].age;
            bld  = q[j].ld;
          end
          if (best <= D) begin
            if (best >= (bld ? 3 : 2)) sel[i*SW +: SW] = SW'(best);
            else ss[i] = 1'b1;
          end
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    logic [NS*SW-1:0] es;
    logic [NS-1:0]    ess;
    prod_t            nq[$];
    model_out(es, ess);
    if (reset) begin
      q.delete();
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
      started     = 1;
    end else if (!pipe_freeze) begin
      if (|ess) m_stall_cnt++;
      else if (|es) m_fwd_cnt++;
      nq = {};
      foreach (q[j]) begin
        prod_t p;
        p = q[j];
        if (p.age < D) begin
          p.age++;
          nq.push_back(p);
        end
      end
      if (id_valid && id_reg_write && id_rd != '0 && !(|ess) && !id_flush)
        nq.push_back('{rd: int'(id_rd), ld: id_mem_read, age: 1});
      q = nq;
    end
  end

  always @(negedge clk) begin
    logic [NS*SW-1:0] es;
    logic [NS-1:0]    ess;
    if (started) begin
      model_out(es, ess);
      chk("model_fwd_sel", 32'(fwd_sel), 32'(es));
      chk("model_stall_id", 32'(stall_id), 32'(|ess));
      chk("model_stall_src", 32'(stall_src), 32'(ess));
`ifdef BRANCH_FWD_STATS_EN
      chk("model_stat_stall", stat_stall_cycles, 32'(m_stall_cnt));
      chk("model_stat_fwd", stat_fwd_events, 32'(m_fwd_cnt));
`endif
    end
  end

  task automatic drive(input logic v, input logic br, input int s0, input int s1,
                       input logic [1:0] used, input int rd, input logic rw, input logic mr);
    id_valid     = v;
    id_is_branch = br;
    id_src       = {AW'(s1), AW'(s0)};
    id_src_used  = used;
    id_rd        = AW'(rd);
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drain();
    nop();
    repeat (3) cyc();
  endtask

  initial begin
    reset = 1'b1; id_flush = 1'b0; pipe_freeze = 1'b0;
    nop();
    cyc(); cyc();
    reset = 1'b0;
    mid();
    chk("reset_fwd_sel", 32'(fwd_sel), 32'h0);
    chk("reset_stall_id", 32'(stall_id), 32'h0);
    chk("reset_stall_src", 32'(stall_src), 32'h0);

    // ALU producer in EX: one stall cycle, then MEM forward on src0
    drive(1, 0, 0, 0, 2'b00, 3, 1, 0); cyc();
    drive(1, 1, 3, 4, 2'b11, 0, 0, 0);
    mid(); chk("alu_stall", 32'(stall_id), 32'h1); chk("alu_stall_src", 32'(stall_src), 32'h1);
    cyc();
    mid(); chk("alu_fwd_mem", 32'(fwd_sel), 32'h2); chk("alu_stall_gone", 32'(stall_id), 32'h0);
    cyc(); drain();

    // Load in EX: two stall cycles, then WB forward on src1; r0 never matches
    drive(1, 0, 0, 0, 2'b00, 5, 1, 1); cyc();
    drive(1, 1, 0, 5, 2'b11, 0, 0, 0);
    mid(); chk("ld_stall1", 32'(stall_id), 32'h1); chk("ld_stall1_src", 32'(stall_src), 32'h2);
    cyc();
    mid(); chk("ld_stall2", 32'(stall_id), 32'h1);
    cyc();
    mid(); chk("ld_fwd_wb", 32'(fwd_sel), 32'hC); chk("ld_stall_gone", 32'(stall_id), 32'h0);
    cyc(); drain();

    // Youngest match wins: ALU r7 in MEM over load r7 in WB
    drive(1, 0, 0, 0, 2'b00, 7, 1, 1); cyc();
    drive(1, 0, 0, 0, 2'b00, 7, 1, 0); cyc();
    nop(); cyc();
    drive(1, 1, 7, 7, 2'b11, 0, 0, 0);
    mid(); chk("youngest_sel", 32'(fwd_sel), 32'hA); chk("youngest_nostall", 32'(stall_id), 32'h0);
    cyc(); drain();

    // Flush beats stall, and the flushed writer becomes a bubble
    drive(1, 0, 0, 0, 2'b00, 9, 1, 0); cyc();
    drive(1, 1, 9, 0, 2'b01, 10, 1, 0);
    mid(); chk("pre_flush_stall", 32'(stall_id), 32'h1);
    id_flush = 1'b1;
    #1; chk("flush_stall", 32'(stall_id), 32'h0);
    cyc();
    id_flush = 1'b0;
    drive(1, 1, 10, 9, 2'b11, 0, 0, 0);
    mid(); chk("flush_bubble_sel", 32'(fwd_sel), 32'h8); chk("flush_bubble_nostall", 32'(stall_id), 32'h0);
    cyc(); drain();

    // Freeze holds entries and the stall for three cycles
    drive(1, 0, 0, 0, 2'b00, 11, 1, 0); cyc();
    drive(1, 1, 11, 0, 2'b01, 0, 0, 0);
    pipe_freeze = 1'b1;
    for (int n = 0; n < 3; n++) begin
      mid(); chk("freeze_stall", 32'(stall_id), 32'h1); chk("freeze_stall_src", 32'(stall_src), 32'h1);
      cyc();
    end
    pipe_freeze = 1'b0;
    mid(); chk("unfreeze_stall", 32'(stall_id), 32'h1);
    cyc();
    mid(); chk("unfreeze_fwd", 32'(fwd_sel), 32'h2); chk("unfreeze_nostall", 32'(stall_id), 32'h0);
    cyc(); drain();

    // Non-branch consumer never stalls
    drive(1, 0, 0, 0, 2'b00, 12, 1, 0); cyc();
    drive(1, 0, 12, 12, 2'b11, 0, 0, 0);
    mid(); chk("nonbranch_nostall", 32'(stall_id), 32'h0); chk("nonbranch_sel", 32'(fwd_sel), 32'h0);
    cyc(); drain();

    // Reset in the middle of a load stall
    drive(1, 0, 0, 0, 2'b00, 13, 1, 1); cyc();
    drive(1, 1, 13, 0, 2'b01, 0, 0, 0);
    mid(); chk("pre_reset_stall", 32'(stall_id), 32'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    mid(); chk("post_reset_stall", 32'(stall_id), 32'h0); chk("post_reset_sel", 32'(fwd_sel), 32'h0);
`ifdef BRANCH_FWD_STATS_EN
    chk("post_reset_stat_stall", stat_stall_cycles, 32'h0);
    chk("post_reset_stat_fwd", stat_fwd_events, 32'h0);
`endif
    cyc();
    drive(1, 0, 0, 0, 2'b00, 14, 1, 1); cyc();
    drive(1, 1, 14, 0, 2'b01, 0, 0, 0);
    mid(); chk("ld2_stall1", 32'(stall_id), 32'h1);
    cyc();
    mid(); chk("ld2_stall2", 32'(stall_id), 32'h1);
    cyc();
    mid(); chk("ld2_fwd_wb", 32'(fwd_sel), 32'h3);
`ifdef BRANCH_FWD_STATS_EN
    chk("stat_stall_two", stat_stall_cycles, 32'h2);
    chk("stat_fwd_zero", stat_fwd_events, 32'h0);
`endif
    cyc();
    nop();
    mid();
`ifdef BRANCH_FWD_STATS_EN
    chk("stat_fwd_one", stat_fwd_events, 32'h1);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
